veerwolf_uart_rx: RTL

- UART receiver (8N1, LSB first) for the VeeRwolf SoC. Pairs with the existing transmit path that drives o_uart_tx.
- Samples the asynchronous i_uart_rx pin in the clk_core domain and deframes bytes into a first-word-fall-through FIFO.
- Exposes the FIFO through a valid/ready read port for the CPU-side bus bridge.
- Flags framing errors and overruns as one-cycle pulses for interrupt and status logic.

---
 rtl/veerwolf_uart_pkg.sv | 18 +
 rtl/veerwolf_sync_fifo.sv | 74 +++++++
 rtl/veerwolf_uart_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/veerwolf_uart_pkg.sv
// rtl/veerwolf_uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose: state encoding for the receive deframer and the frame data width.
// Ports: none (package).

package veerwolf_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/veerwolf_sync_fifo.sv
// rtl/veerwolf_sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose: FWFT queue; the head entry is visible on rdata whenever empty=0.
// Ports:
//   clk_core, rst_core : clock and synchronous active-high reset
//   push, wdata        : write request and data
//   pop                : remove head entry (ignored while empty)
//   rdata              : head entry, read combinationally from storage
//   empty, full        : status flags
//   level              : current entry count, 0..DEPTH

module veerwolf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still lands. An empty FIFO never bypasses a push straight to rdata.
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/veerwolf_uart_rx.sv
// rtl/veerwolf_uart_rx.sv - 8N1 UART receiver with FWFT receive FIFO
//
// Purpose: synchronizes the serial line, deframes LSB-first bytes and
// queues them; flags framing errors and overruns as one-cycle pulses.
// Ports:
//   clk_core, rst_core : clock and synchronous active-high reset
//   i_uart_rx          : asynchronous serial input, idles high
//   o_rdata, o_rvalid  : FIFO head byte and not-empty flag
//   i_rready           : pops the head when o_rvalid=1
//   o_frame_err        : pulse, stop bit sampled low
//   o_overrun          : pulse, completed byte dropped on a full FIFO
//   o_fifo_level       : current FIFO entry count

module veerwolf_uart_rx
  import veerwolf_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_core,
  input  logic                          rst_core,
  input  logic                          i_uart_rx,
  output logic [UART_DATA_BITS-1:0]     o_rdata,
  output logic                          o_rvalid,
  input  logic                          i_rready,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int BW   = $clog2(UART_DATA_BITS);

  uart_rx_state_t            state_q, state_d;
  logic                      sync1_q;
  logic                      rx_s_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;

  logic                      push;
  logic                      expire;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      pop_fire;

  assign o_rvalid    = ~fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign pop_fire    = i_rready & ~fifo_empty;
  assign expire      = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
            cnt_d     = CW'(BAUD_DIV - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d              = CW'(BAUD_DIV - 1);
          if (bit_idx_q == BW'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s_q) begin
            // A simultaneous pop makes room, so only a truly blocked push overruns.
            if (fifo_full && !pop_fire) begin
              overrun_d = 1'b1;
            end else begin
              push = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BREAK: begin
        // Hold here until the line releases so a long break reports only once.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= i_uart_rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  veerwolf_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .push     (push),
    .wdata    (shift_d),
    .pop      (i_rready),
    .rdata    (o_rdata),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (o_fifo_level)
  );

endmodule
